// File: rtl/uart_tx_fifo.sv
// RS-232 transmitter with a transmit FIFO and a compile-time frame format.
// Queued words leave as back-to-back frames with no idle cycle between them.
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_BITS-1:0]                data,
  input  logic                                start_tx,
  output logic                                tx,
  output logic                                tx_ready,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(DIV);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP   = STOP_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL        = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
    return (^w) ^ (PARITY == 1);
  endfunction

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [STOP_W-1:0]    stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [0:FIFO_DEPTH-1];

  logic                 wr_en, pop, load, baud_done, fifo_nempty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready    = (count_q != FULL);
  assign wr_en       = start_tx && tx_ready;
  assign fifo_nempty = (count_q != '0);
  assign baud_done   = (baud_q == '0);
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    tx_d     = tx_q;
    load     = 1'b0;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        load = fifo_nempty;
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == LAST_BIT) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              stop_d  = '0;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b1;
          stop_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          if (stop_q == LAST_STOP) begin
            // Next queued word starts on this very edge: no idle gap.
            load = fifo_nempty;
            if (!fifo_nempty) begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + STOP_W'(1);
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      shreg_d = head;
      par_d   = parity_bit(head);
      tx_d    = 1'b0;
      baud_d  = BAUD_RELOAD;
      state_d = S_START;
    end

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised RS-232 transmitter with a built-in transmit FIFO and compile-time frame format. It replaces the fixed 9600-baud, 8-bit, single-byte transmitter. Word width, parity, stop-bit count, baud divisor and buffer depth are all configurable, and queued words go out as gapless back-to-back frames. It sits between any byte-producing logic and the board's serial TX pin.

## Interface
- CLK_HZ, 50_000_000, clk frequency in Hz
- BAUD, 9600, line rate; bit period DIV = (CLK_HZ + BAUD/2) / BAUD cycles, must be ≥ 2
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, power of two, ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, synchronous, active-high
- data  input  DATA_BITS  word to queue
- start_tx  input  1  write strobe; accepted only when tx_ready = 1
- tx  output  1  serial line, idle high
- tx_ready  output  1  FIFO not full (fifo_count < FIFO_DEPTH)
- busy  output  1  frame in progress or FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH+1)  words queued, excluding the word being shifted

## Operation
- Reset values: tx = 1, tx_ready = 1, busy = 0, fifo_count = 0, FSM = IDLE.
- Reset mid-frame: the frame is aborted, the FIFO is flushed, and tx = 1 after the reset edge.
- Frame order: start bit (0), data LSB first, optional parity bit, STOP_BITS stop bits (1).
- Parity:
  - Odd: data ones + parity bit = odd count.
  - Even: data ones + parity bit = even count.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when fifo_count ≠ 0. The FIFO pops on that edge, the word goes to the shift register, and tx is registered 0.
  - START → DATA after DIV cycles.
  - DATA → PARITY (PARITY ≠ 0) or STOP (PARITY = 0) after DATA_BITS × DIV cycles.
  - PARITY → STOP after DIV cycles.
  - STOP, after STOP_BITS × DIV cycles:
    - fifo_count ≠ 0 → START directly; pop and tx = 0 on the same edge, so there is no idle cycle between frames.
    - fifo_count = 0 → IDLE.
- tx is driven from a register only; it is glitch-free and never combinational.
- A single baud counter reloads to DIV−1 at each bit boundary. Bit and stop counters are sized for DATA_BITS and STOP_BITS.
- FIFO write occurs when start_tx = 1 and tx_ready = 1.
  - start_tx while full is ignored: no overwrite, no count change.
- Write and pop on the same edge: fifo_count unchanged, both operations take effect.
  - When full, the write is still rejected even if a pop occurs that edge, because tx_ready is evaluated before the edge.
- Read/write pointers wrap modulo FIFO_DEPTH. fifo_count saturates at neither end, since full and empty are guarded.

## Timing
- Write sampled at edge N into an idle, empty block: tx falls after edge N+1, and busy = 1 after edge N.
- Every bit, including parity and stop bits, is held exactly DIV cycles.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
- busy falls on the edge that ends the last stop bit when the FIFO is empty.
- tx_ready and fifo_count update on the edge after a write or pop, with no extra latency.

## Test plan
- 8N1, DIV = 16, write 0x55 once:
  - tx = 0 for 16 cycles, then 1,0,1,0,1,0,1,0 (16 cycles each), then 1 for 16 cycles.
  - busy falls exactly 160 cycles after tx falls.
- PARITY = 2, data 0x07: parity bit = 1. PARITY = 1, data 0x07: parity bit = 0. PARITY = 1, data 0x00: parity bit = 1.
- DATA_BITS = 7, STOP_BITS = 2, DIV = 16, data 0x41: frame 0,1,0,0,0,0,0,1,1,1, total 160 cycles.
- FIFO_DEPTH = 4, start_tx held high with data 0x10..0x15 on six consecutive cycles:
  - 0x10..0x14 accepted; the first pop keeps one slot free.
  - fifo_count reaches 4, tx_ready = 0, and 0x15 is dropped.
  - Five contiguous frames with no idle gap, then tx = 1 and busy = 0.
- Assert rst for one cycle in the middle of the 3rd data bit with 3 words queued:
  - After the edge: tx = 1, fifo_count = 0, tx_ready = 1, busy = 0.
  - No further frames are sent.
- Write while full on the same edge a frame ends (pop): write rejected, fifo_count goes 4 → 3, the popped word is transmitted next.
